// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and memory read-port signals shared by the arbiter.
// slave = the arbiter itself, master = the caches and memory around it.
interface cache_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  icache_rd_req;
   logic [ADDR_WIDTH-1:0] icache_rd_addr;
   logic                  icache_addr_ok;
   logic                  icache_ret_valid;
   logic [LINE_WIDTH-1:0] icache_ret_data;
   logic                  dcache_rd_req;
   logic [ADDR_WIDTH-1:0] dcache_rd_addr;
   logic                  dcache_rd_uncached;
   logic                  dcache_addr_ok;
   logic                  dcache_ret_valid;
   logic [LINE_WIDTH-1:0] dcache_ret_data;
   logic                  mem_rd_req;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [2:0]            mem_rd_type;
   logic                  mem_addr_ok;
   logic                  mem_ret_valid;
   logic [LINE_WIDTH-1:0] mem_ret_data;
   logic                  busy;
   logic                  owner;
   logic                  err_timeout;
   logic                  err_clr;

   modport slave (
      input  icache_rd_req, icache_rd_addr, dcache_rd_req, dcache_rd_addr, dcache_rd_uncached,
             mem_addr_ok, mem_ret_valid, mem_ret_data, err_clr,
      output icache_addr_ok, icache_ret_valid, icache_ret_data,
             dcache_addr_ok, dcache_ret_valid, dcache_ret_data,
             mem_rd_req, mem_rd_addr, mem_rd_type, busy, owner, err_timeout
   );

   modport master (
      output icache_rd_req, icache_rd_addr, dcache_rd_req, dcache_rd_addr, dcache_rd_uncached,
             mem_addr_ok, mem_ret_valid, mem_ret_data, err_clr,
      input  icache_addr_ok, icache_ret_valid, icache_ret_data,
             dcache_addr_ok, dcache_ret_valid, dcache_ret_data,
             mem_rd_req, mem_rd_addr, mem_rd_type, busy, owner, err_timeout
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory read port between icache and dcache, one transaction at a time.
// Grant seen on mem_rd_req one cycle after the request; losers hold req until their addr_ok.
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_WIDTH     = 256,
   parameter bit RR_EN          = 1'b1,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cache_mem_arbiter_if.slave   bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RET} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_owner;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_type;
   logic [CW-1:0]         r_wdog;
   logic                  r_err;
   logic                  r_icache_ret_valid;
   logic                  r_dcache_ret_valid;
   logic [LINE_WIDTH-1:0] r_icache_ret_data;
   logic [LINE_WIDTH-1:0] r_dcache_ret_data;

   logic                  w_any_req;
   logic                  w_grant_d;
   logic                  w_ret;
   logic                  w_expire;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic [2:0]            w_gnt_type;
   logic [LINE_WIDTH-1:0] w_ret_data;

   assign w_any_req = bus.icache_rd_req || bus.dcache_rd_req;
   // r_owner doubles as last_grant: on a tie round-robin picks the other side.
   assign w_grant_d = bus.dcache_rd_req && (!bus.icache_rd_req || !RR_EN || !r_owner);
   assign w_ret     = (r_state == WAIT_RET) && bus.mem_ret_valid;
   assign w_expire  = (r_state == WAIT_RET) && !bus.mem_ret_valid
                      && (r_wdog == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_gnt_addr = {bus.icache_rd_addr[ADDR_WIDTH-1:4], 4'h0};
      w_gnt_type = 3'b100;
      if (w_grant_d) begin
         if (bus.dcache_rd_uncached) begin
            w_gnt_addr = {bus.dcache_rd_addr[ADDR_WIDTH-1:2], 2'b00};
            w_gnt_type = 3'b010;
         end else begin
            w_gnt_addr = {bus.dcache_rd_addr[ADDR_WIDTH-1:4], 4'h0};
            w_gnt_type = 3'b100;
         end
      end
   end

   // A timeout returns zero data so the owner is released rather than left hanging.
   always_comb begin
      w_ret_data = '0;
      if (w_ret) begin
         if (r_type == 3'b010) begin
            w_ret_data = {{(LINE_WIDTH-32){1'b0}}, bus.mem_ret_data[31:0]};
         end else begin
            w_ret_data = bus.mem_ret_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_any_req)          w_state_nxt = REQ;
         REQ:      if (bus.mem_addr_ok)    w_state_nxt = WAIT_RET;
         WAIT_RET: if (w_ret || w_expire)  w_state_nxt = IDLE;
         default:                          w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner            <= 1'b0;
         r_addr             <= '0;
         r_type             <= '0;
         r_wdog             <= '0;
         r_err              <= 1'b0;
         r_icache_ret_valid <= 1'b0;
         r_dcache_ret_valid <= 1'b0;
         r_icache_ret_data  <= '0;
         r_dcache_ret_data  <= '0;
      end else begin
         r_icache_ret_valid <= 1'b0;
         r_dcache_ret_valid <= 1'b0;
         if ((r_state == IDLE) && w_any_req) begin
            r_owner <= w_grant_d;
            r_addr  <= w_gnt_addr;
            r_type  <= w_gnt_type;
         end
         if (w_ret || w_expire) begin
            if (r_owner) begin
               r_dcache_ret_valid <= 1'b1;
               r_dcache_ret_data  <= w_ret_data;
            end else begin
               r_icache_ret_valid <= 1'b1;
               r_icache_ret_data  <= w_ret_data;
            end
         end
         if ((r_state == WAIT_RET) && !w_ret && !w_expire) begin
            r_wdog <= r_wdog + CW'(1);
         end else begin
            r_wdog <= '0;
         end
         if (w_expire) begin
            r_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bus.mem_rd_req       = (r_state == REQ);
   assign bus.mem_rd_addr      = r_addr;
   assign bus.mem_rd_type      = r_type;
   assign bus.icache_addr_ok   = bus.mem_addr_ok && (r_state == REQ) && !r_owner;
   assign bus.dcache_addr_ok   = bus.mem_addr_ok && (r_state == REQ) && r_owner;
   assign bus.icache_ret_valid = r_icache_ret_valid;
   assign bus.icache_ret_data  = r_icache_ret_data;
   assign bus.dcache_ret_valid = r_dcache_ret_valid;
   assign bus.dcache_ret_data  = r_dcache_ret_data;
   assign bus.busy             = (r_state != IDLE);
   assign bus.owner            = r_owner;
   assign bus.err_timeout      = r_err;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a round-robin and a fixed-priority instance share one stimulus
// path (sel picks which is live), checked against a transaction-level model of grants and returns.
module tb_cache_mem_arbiter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         sel;
   logic         t_ireq, t_dreq, t_unc, t_maok, t_mrv, t_eclr;
   logic [31:0]  t_iaddr, t_daddr;
   logic [255:0] t_mdata;

   logic         o_iaok, o_irv, o_daok, o_drv, o_mreq, o_busy, o_owner, o_err;
   logic [255:0] o_ird, o_drd;
   logic [31:0]  o_maddr;
   logic [2:0]   o_mtype;

   int err_cnt = 0;
   int chk_cnt = 0;

   // transaction-level model state
   bit           pend_i, pend_d, unc_d, last;
   logic [31:0]  addr_i, addr_d;
   logic [255:0] exp_id, exp_dd;

   always #5 clk = ~clk;

   cache_mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) if_rr ();
   cache_mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) if_fp ();

   cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .RR_EN(1'b1), .TIMEOUT_CYCLES(8))
      u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));
   cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .RR_EN(1'b0), .TIMEOUT_CYCLES(8))
      u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));

   assign if_rr.icache_rd_req      = t_ireq & ~sel;
   assign if_rr.dcache_rd_req      = t_dreq & ~sel;
   assign if_rr.mem_addr_ok        = t_maok & ~sel;
   assign if_rr.mem_ret_valid      = t_mrv  & ~sel;
   assign if_rr.err_clr            = t_eclr & ~sel;
   assign if_rr.icache_rd_addr     = t_iaddr;
   assign if_rr.dcache_rd_addr     = t_daddr;
   assign if_rr.dcache_rd_uncached = t_unc;
   assign if_rr.mem_ret_data       = t_mdata;
   assign if_fp.icache_rd_req      = t_ireq & sel;
   assign if_fp.dcache_rd_req      = t_dreq & sel;
   assign if_fp.mem_addr_ok        = t_maok & sel;
   assign if_fp.mem_ret_valid      = t_mrv  & sel;
   assign if_fp.err_clr            = t_eclr & sel;
   assign if_fp.icache_rd_addr     = t_iaddr;
   assign if_fp.dcache_rd_addr     = t_daddr;
   assign if_fp.dcache_rd_uncached = t_unc;
   assign if_fp.mem_ret_data       = t_mdata;

   assign o_iaok   = sel ? if_fp.icache_addr_ok   : if_rr.icache_addr_ok;
   assign o_irv    = sel ? if_fp.icache_ret_valid : if_rr.icache_ret_valid;
   assign o_ird    = sel ? if_fp.icache_ret_data  : if_rr.icache_ret_data;
   assign o_daok   = sel ? if_fp.dcache_addr_ok   : if_rr.dcache_addr_ok;
   assign o_drv    = sel ? if_fp.dcache_ret_valid : if_rr.dcache_ret_valid;
   assign o_drd    = sel ? if_fp.dcache_ret_data  : if_rr.dcache_ret_data;
   assign o_mreq   = sel ? if_fp.mem_rd_req       : if_rr.mem_rd_req;
   assign o_maddr  = sel ? if_fp.mem_rd_addr      : if_rr.mem_rd_addr;
   assign o_mtype  = sel ? if_fp.mem_rd_type      : if_rr.mem_rd_type;
   assign o_busy   = sel ? if_fp.busy             : if_rr.busy;
   assign o_owner  = sel ? if_fp.owner            : if_rr.owner;
   assign o_err    = sel ? if_fp.err_timeout      : if_rr.err_timeout;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      {t_ireq, t_dreq, t_unc, t_maok, t_mrv, t_eclr} = '0;
      t_iaddr = '0; t_daddr = '0; t_mdata = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      pend_i = 0; pend_d = 0; unc_d = 0; last = 0;
      exp_id = '0; exp_dd = '0;
   endtask

   // Entered one step after an edge with the DUT idle; leaves in the cycle after the return pulse.
   task automatic txn(input bit new_i, input bit new_d, input logic [31:0] ai, input logic [31:0] ad,
                      input bit unc, input int adly, input int rdly, input logic [255:0] data,
                      input bit stray);
      bit           win;
      logic [31:0]  ea;
      logic [2:0]   et;
      logic [255:0] ed;
      if (new_i && !pend_i) begin pend_i = 1; addr_i = ai; t_ireq = 1; t_iaddr = ai; end
      if (new_d && !pend_d) begin pend_d = 1; addr_d = ad; unc_d = unc; t_dreq = 1; t_daddr = ad; t_unc = unc; end
      if (!pend_i && !pend_d) begin pend_i = 1; addr_i = ai; t_ireq = 1; t_iaddr = ai; end
      if (pend_i && pend_d) win = sel ? 1'b1 : ~last;
      else                  win = pend_d;
      last = win;
      if (win && unc_d) begin ea = {addr_d[31:2], 2'b00}; et = 3'b010; end
      else if (win)     begin ea = {addr_d[31:4], 4'h0};  et = 3'b100; end
      else              begin ea = {addr_i[31:4], 4'h0};  et = 3'b100; end

      @(posedge clk); #1;
      check_val("req_vld",   o_mreq,  1'b1);
      check_val("req_addr",  o_maddr, ea);
      check_val("req_type",  o_mtype, et);
      check_val("owner",     o_owner, win);
      check_val("busy_req",  o_busy,  1'b1);
      for (int c = 0; c < adly; c++) begin
         if (stray && $urandom_range(0, 2) == 0) begin t_mrv = 1; t_mdata = rand_line(); end
         @(posedge clk); #1;
         t_mrv = 0;
         check_val("req_hold", {o_mreq, o_maddr, o_mtype}, {1'b1, ea, et});
         check_val("no_ret_in_req", {o_irv, o_drv, o_iaok, o_daok}, 4'b0);
      end
      t_maok = 1; #1;
      check_val("addr_ok", {o_iaok, o_daok}, {~win, win});
      @(posedge clk); #1;
      t_maok = 0;
      if (win) begin pend_d = 0; t_dreq = 0; end
      else     begin pend_i = 0; t_ireq = 0; end
      check_val("wait_state", {o_busy, o_mreq}, 2'b10);
      for (int c = 0; c < rdly; c++) begin
         @(posedge clk); #1;
         check_val("no_early_ret", {o_irv, o_drv}, 2'b0);
      end
      t_mrv = 1; t_mdata = data;
      @(posedge clk); #1;
      t_mrv = 0;
      ed = (win && unc_d) ? {224'b0, data[31:0]} : data;
      if (win) exp_dd = ed; else exp_id = ed;
      check_val("ret_vld",  {o_irv, o_drv}, {~win, win});
      check_val("i_data",   o_ird, exp_id);
      check_val("d_data",   o_drd, exp_dd);
      check_val("busy_end", o_busy, 1'b0);
   endtask

   task automatic rand_txns(input int n);
      for (int k = 0; k < n; k++)
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5), rand_line(), 1'b1);
   endtask

   task automatic timeout_test();
      int c;
      t_dreq = 1; t_daddr = 32'h4000_0040; t_unc = 0;
      @(posedge clk); #1;
      check_val("to_owner", o_owner, 1'b1);
      t_maok = 1;
      @(posedge clk); #1;
      t_maok = 0; t_dreq = 0;
      t_eclr = 1;
      c = 0;
      while (!o_drv && c < 20) begin
         @(posedge clk); #1;
         c++;
      end
      t_eclr = 0;
      check_val("to_pulse",  o_drv, 1'b1);
      check_val("to_cycles", c, 8);
      check_val("to_data",   o_drd, '0);
      check_val("to_err",    o_err, 1'b1);
      check_val("to_busy",   o_busy, 1'b0);
      exp_dd = '0;
      repeat (3) @(posedge clk);
      #1 check_val("err_sticky", o_err, 1'b1);
      t_eclr = 1;
      @(posedge clk); #1;
      t_eclr = 0;
      check_val("err_clr", o_err, 1'b0);
   endtask

   task automatic reset_mid_test();
      t_dreq = 1; t_daddr = 32'h2000_0100; t_unc = 0;
      @(posedge clk); #1;
      t_maok = 1;
      @(posedge clk); #1;
      t_maok = 0;
      check_val("mid_busy", {o_busy, o_owner}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_outs", {o_busy, o_owner, o_mreq, o_irv, o_drv, o_err, o_mtype, o_maddr}, '0);
      t_dreq = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      t_mrv = 1; t_mdata = rand_line();
      @(posedge clk); #1;
      t_mrv = 0;
      check_val("rst_no_ret", {o_irv, o_drv, o_busy}, 3'b0);
      check_val("rst_data",   {o_ird, o_drd}, '0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      sel = 1'b0;
      do_reset();
      check_val("rst_ctrl", {o_iaok, o_irv, o_daok, o_drv, o_mreq, o_busy, o_owner, o_err}, 8'b0);
      check_val("rst_addr", {o_maddr, o_mtype}, '0);
      check_val("rst_idata", o_ird, '0);
      check_val("rst_ddata", o_drd, '0);

      txn(1'b1, 1'b0, 32'h1C00_0014, 32'h0, 1'b0, 2, 2, {32{8'hA5}}, 1'b0);

      do_reset();
      txn(1'b1, 1'b1, 32'h1000_0004, 32'h2000_0008, 1'b0, 0, 0, rand_line(), 1'b0);
      txn(1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1, 1, rand_line(), 1'b0);
      txn(1'b1, 1'b1, 32'h1000_0104, 32'h2000_0208, 1'b0, 0, 3, rand_line(), 1'b0);

      do_reset();
      txn(1'b0, 1'b1, 32'h0, 32'h8000_0006, 1'b1, 1, 1, {256{1'b1}}, 1'b0);
      rand_txns(40);

      do_reset();
      timeout_test();
      do_reset();
      reset_mid_test();

      sel = 1'b1;
      do_reset();
      txn(1'b1, 1'b1, 32'h3000_0010, 32'h5000_0020, 1'b0, 0, 0, rand_line(), 1'b0);
      txn(1'b0, 1'b1, 32'h0,         32'h5000_0124, 1'b1, 1, 0, rand_line(), 1'b0);
      txn(1'b0, 1'b1, 32'h0,         32'h5000_0238, 1'b0, 0, 2, rand_line(), 1'b0);
      txn(1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 0, 0, rand_line(), 1'b0);
      rand_txns(30);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
